icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-frame instruction cache that is the responder end of the datapath's instruction-fetch request (`imemREN`/`imemaddr` → `ihit`/`imemload`). It sits between the pipelined datapath and the memory controller's instruction port (`iREN`/`iaddr` → `iwait`/`iload`). It answers hits combinationally in the same cycle and fills misses from memory with a two-state FSM. Hit and miss counters are kept for performance runs.

## Interface
- `SETS`, 16, number of frames; power of two, ≥2
- `CLK` in 1: sole clock, rising edge
- `RST` in 1: reset, synchronous and active-high
- `imemREN` in 1: datapath fetch request
- `imemaddr` in 32: fetch byte address; bits [1:0] ignored
- `ihit` out 1: `imemload` valid this cycle
- `imemload` out 32: instruction word; 0 whenever `ihit`=0
- `iREN` out 1: read request to memory controller
- `iaddr` out 32: word-aligned miss address
- `iwait` in 1: memory busy; `iload` valid in a cycle with `iREN`=1 and `iwait`=0
- `iload` in 32: memory read data
- `inv_all` in 1: invalidate all frames
- `hit_count` out 32: array-hit counter
- `miss_count` out 32: miss counter

## Operation
- Address split: `idx` = addr[2+IW-1:2], where IW = log2(SETS); `tag` = addr[31:2+IW], which is 26 bits at SETS=16.
- Frame contents: `valid`, `tag`, `data`. Only `valid` is reset (to 0).
- FSM states:
  - IDLE:
    - `ihit` = `imemREN` && `valid[idx]` && tag match && !`inv_all`; `imemload` = `data[idx]`.
    - `imemREN` && !hit → latch word address `{imemaddr[31:2],2'b00}` into `maddr`; `miss_count`++; go to FETCH.
  - FETCH:
    - `iREN`=1, `iaddr`=`maddr`. All array lookups are suppressed.
    - On `iwait`=0: write `data[idx(maddr)]`=`iload`, set `tag` and `valid`; return to IDLE.
    - Forwarding: in that same cycle, if `imemREN` && `imemaddr[31:2]`==`maddr[31:2]`, then `ihit`=1 and `imemload`=`iload`.
- Address change mid-FETCH (branch/jump redirect): the fill still completes to `maddr` with no forwarded hit. The new address is looked up in IDLE on the next cycle.
- `imemREN` dropped mid-FETCH: the fill completes, no `ihit`.
- `inv_all` in IDLE: all `valid` bits clear on the next edge, and `ihit`=0 that cycle.
- `inv_all` in FETCH: latched as pending. It is applied on the fill edge, which also clears the just-filled frame; the forwarded hit is still given.
- `hit_count`++ on every IDLE cycle with `ihit`=1. Forwarded fill hits are not counted.
- Both counters wrap modulo 2^32.

## Timing
- Reset edge, with `RST` sampled high:
  - state=IDLE, all `valid`=0, `maddr`=0, counters=0, pending-invalidate=0.
  - Outputs after that edge: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- `iaddr` is 0 in IDLE.
- Reset mid-FETCH abandons the request: `iREN` is low from the next cycle and no frame is written.
- Hit latency: 0 cycles (combinational).
- Miss latency: 1 IDLE cycle plus N FETCH cycles, where N is the number of cycles until `iwait`=0. With single-cycle memory the word arrives 1 cycle after the miss.
- `iREN` stays high continuously from FETCH entry to the fill cycle inclusive. `maddr` does not change during FETCH.
- A fill and an IDLE lookup never occur in the same cycle.

## Structure
- Add `icachef_t` (packed: `tag`, `idx`, `bytoff`) and `icache_frame_t` (`valid`, `tag`, `word_t data`) to `cpu_types_pkg`. The tag and index widths are derived there from a `ICACHE_SETS` localparam, default 16.
- Add an `icache_state_t` enum {IDLE, FETCH} to the same package.
- Single module, no sub-modules. The frame array is a register array written only on the fill edge.

## Test plan
- Cold miss: after reset, `imemREN`=1, `imemaddr`=0x0000_0040, memory `iwait`=1 for 3 cycles and then `iload`=0x2402_0005 → `iREN` high for 4 cycles with `iaddr`=0x40. `ihit`=1 and `imemload`=0x2402_0005 on the fill cycle. `miss_count`=1, `hit_count`=0.
- Re-access 0x40 → same-cycle `ihit`=1 with `imemload`=0x2402_0005, `iREN`=0, `hit_count`=1.
- Conflict: fill 0x40, then request 0x80 (same idx 0, different tag) → miss that fills idx 0. A later request to 0x40 misses again; `miss_count`=3.
- Redirect: during FETCH of 0x100, `imemaddr` changes to 0x200 → fill of 0x100 completes with `ihit`=0. The next cycle is a miss on 0x200, and a later access to 0x100 hits.
- Invalidate: fill 0x0 and 0x4, pulse `inv_all` in IDLE → both addresses miss afterwards. `inv_all` asserted during FETCH of 0x8 → forwarded hit is given, then 0x8 misses on re-access.
- `RST` high during FETCH → `iREN`=0 and counters=0 next cycle; a request to the aborted address misses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split, frame layout and fill FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS = 16;
  localparam int ICACHE_IW   = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAGW = 30 - ICACHE_IW;

  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IW-1:0]   idx;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Datapath instruction-fetch port: the datapath is master, the cache answers as slave.
interface icache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output imemREN, output imemaddr, input ihit, input imemload);
  modport slave  (input imemREN, input imemaddr, output ihit, output imemload);
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with combinational hits,
// a two-state miss-fill FSM and hit/miss performance counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic     CLK,
  input  logic     RST,
  icache_if.slave  dp,
  output logic     iREN,
  output word_t    iaddr,
  input  logic     iwait,
  input  word_t    iload,
  input  logic     inv_all,
  output word_t    hit_count,
  output word_t    miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  icache_state_t state_q, state_d;
  word_t         maddr_q;
  logic          inv_pend_q;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0] tag_q [SETS];
  word_t         data_q [SETS];
  word_t         hit_count_q, miss_count_q;

  logic [IW-1:0] req_idx, fill_idx;
  logic [TW-1:0] req_tag, fill_tag;
  logic          lookup_hit, miss, fill;
  logic          unused_bytoff;

  assign req_idx       = dp.imemaddr[2 +: IW];
  assign req_tag       = dp.imemaddr[31:2+IW];
  assign fill_idx      = maddr_q[2 +: IW];
  assign fill_tag      = maddr_q[31:2+IW];
  assign unused_bytoff = ^dp.imemaddr[1:0];

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d     = state_q;
    dp.ihit     = 1'b0;
    dp.imemload = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    lookup_hit  = 1'b0;
    miss        = 1'b0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        lookup_hit = dp.imemREN && valid_q[req_idx] &&
                     (tag_q[req_idx] == req_tag) && !inv_all;
        if (lookup_hit) begin
          dp.ihit     = 1'b1;
          dp.imemload = data_q[req_idx];
        end else if (dp.imemREN) begin
          miss    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = maddr_q;
        if (!iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
          // Forward the returning word only if the datapath still wants this address.
          if (dp.imemREN && (dp.imemaddr[31:2] == maddr_q[31:2])) begin
            dp.ihit     = 1'b1;
            dp.imemload = iload;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      maddr_q      <= '0;
      inv_pend_q   <= 1'b0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        maddr_q      <= {dp.imemaddr[31:2], 2'b00};
        miss_count_q <= miss_count_q + 32'd1;
      end
      if (lookup_hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (state_q == IDLE && inv_all) begin
        valid_q <= '0;
      end
      if (state_q == FETCH && inv_all) begin
        inv_pend_q <= 1'b1;
      end
      // A pending or concurrent invalidate wipes the array, including the frame being filled.
      if (fill) begin
        if (inv_pend_q || inv_all) begin
          valid_q <= '0;
        end else begin
          valid_q[fill_idx] <= 1'b1;
        end
        inv_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle comparison against a map-based cache model
// plus directed scenarios with hand-computed expectations.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  iREN, iwait, inv_all;
  word_t iaddr, iload, hit_count, miss_count;

  icache_if dp();

  icache #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST), .dp(dp),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .inv_all(inv_all), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Memory: word content is a fixed function of address; latency counts busy cycles.
  function automatic word_t memfn(input word_t a);
    if (a == 32'h40) return 32'h2402_0005;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  int lat  = 0;
  int wcnt = 0;
  always @(posedge CLK) wcnt <= (iREN && iwait) ? wcnt + 1 : 0;
  assign iwait = (wcnt < lat);
  always_comb iload = memfn(iaddr);

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: which word address each index holds, plus an outstanding-fetch record.
  logic [29:0] line_of [int];
  bit    m_busy = 0, m_inv = 0;
  word_t m_pend = '0;
  word_t m_hc = '0, m_mc = '0;

  always @(negedge CLK) begin
    word_t a, e_load, e_addr;
    logic  e_hit, e_ren, m_fill;
    int    idx;
    a      = dp.imemaddr;
    idx    = int'(a[5:2]);
    m_fill = 1'b0;
    if (!m_busy) begin
      e_hit  = dp.imemREN && line_of.exists(idx) && (line_of[idx] == a[31:2]) && !inv_all;
      e_load = e_hit ? memfn({a[31:2], 2'b00}) : '0;
      e_ren  = 1'b0;
      e_addr = '0;
    end else begin
      m_fill = !iwait;
      e_hit  = m_fill && dp.imemREN && (a[31:2] == m_pend[31:2]);
      e_load = e_hit ? memfn(m_pend) : '0;
      e_ren  = 1'b1;
      e_addr = m_pend;
    end
    if (chk_en) begin
      chk("cyc_ihit", {31'd0, dp.ihit}, {31'd0, e_hit});
      chk("cyc_imemload", dp.imemload, e_load);
      chk("cyc_iREN", {31'd0, iREN}, {31'd0, e_ren});
      chk("cyc_iaddr", iaddr, e_addr);
      chk("cyc_hit_count", hit_count, m_hc);
      chk("cyc_miss_count", miss_count, m_mc);
    end
    if (RST) begin
      line_of.delete();
      m_busy = 0; m_inv = 0; m_pend = '0; m_hc = '0; m_mc = '0;
    end else if (!m_busy) begin
      if (e_hit) m_hc++;
      else if (dp.imemREN) begin
        m_mc++;
        m_busy = 1;
        m_pend = {a[31:2], 2'b00};
      end
      if (inv_all) line_of.delete();
    end else begin
      if (inv_all) m_inv = 1;
      if (m_fill) begin
        if (m_inv) line_of.delete();
        else line_of[int'(m_pend[5:2])] = m_pend[31:2];
        m_busy = 0;
        m_inv  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue a fetch and hold it until ihit; reports the number of iREN cycles seen.
  task automatic req(input word_t a, input int lt, output int nren, output word_t word);
    bit got;
    got  = 0;
    nren = 0;
    word = '0;
    dp.imemREN  = 1'b1;
    dp.imemaddr = a;
    lat = lt;
    for (int k = 0; k < 16 && !got; k++) begin
      #2;
      if (iREN) nren++;
      if (dp.ihit) begin
        got  = 1;
        word = dp.imemload;
      end
      tick();
    end
    chk("req_timeout", {31'd0, got}, 32'd1);
    dp.imemREN = 1'b0;
    $display("[TB] req addr=%h iren_cycles=%0d word=%h hits=%0d misses=%0d",
             a, nren, word, hit_count, miss_count);
  endtask

  initial begin
    int    n;
    word_t w;
    bit    got;
    RST = 1'b1; inv_all = 1'b0; dp.imemREN = 1'b0; dp.imemaddr = '0;
    tick();
    chk_en = 1;
    tick();
    RST = 1'b0;
    #2;
    chk("rst_ihit", {31'd0, dp.ihit}, 32'd0);
    chk("rst_imemload", dp.imemload, 32'd0);
    chk("rst_iREN", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_counts", hit_count | miss_count, 32'd0);
    tick();

    req(32'h40, 3, n, w);
    chk("cold_iren_cycles", n, 4);
    chk("cold_word", w, 32'h2402_0005);
    chk("cold_miss", miss_count, 1);
    chk("cold_hit", hit_count, 0);

    req(32'h40, 3, n, w);
    chk("reacc_iren", n, 0);
    chk("reacc_word", w, 32'h2402_0005);
    chk("reacc_hit", hit_count, 1);

    req(32'h80, 0, n, w);
    chk("conflict_80_iren", n, 1);
    req(32'h40, 0, n, w);
    chk("conflict_40_iren", n, 1);
    chk("conflict_miss", miss_count, 3);

    // Redirect mid-fetch: 0x104 fill completes without a forwarded hit.
    dp.imemREN = 1'b1; dp.imemaddr = 32'h104; lat = 2;
    tick();
    dp.imemaddr = 32'h208;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      #2;
      if (!iREN) break;
      chk("redir_no_fwd", {31'd0, dp.ihit}, 32'd0);
      n++;
      tick();
    end
    chk("redir_fetch_cycles", n, 3);
    chk("redir_new_lookup", {31'd0, dp.ihit}, 32'd0);
    $display("[TB] redirect 0x104->0x208 fetch_cycles=%0d", n);
    tick();
    req(32'h208, 0, n, w);
    chk("redir_208_iren", n, 1);
    req(32'h104, 0, n, w);
    chk("redir_104_hit", n, 0);
    chk("redir_104_word", w, 32'hBFEB_0104);

    req(32'h0, 0, n, w);
    req(32'h4, 0, n, w);
    dp.imemREN = 1'b1; dp.imemaddr = 32'h0; inv_all = 1'b1;
    #2;
    chk("inv_idle_ihit", {31'd0, dp.ihit}, 32'd0);
    tick();
    inv_all = 1'b0;
    $display("[TB] inv_all pulse in IDLE");
    req(32'h0, 0, n, w);
    chk("inv_0_iren", n, 1);
    req(32'h4, 0, n, w);
    chk("inv_4_iren", n, 1);

    dp.imemREN = 1'b1; dp.imemaddr = 32'h8; lat = 2;
    tick();
    inv_all = 1'b1;
    got = 0;
    for (int k = 0; k < 16 && !got; k++) begin
      #2;
      if (dp.ihit) begin
        got = 1;
        w   = dp.imemload;
      end
      tick();
    end
    inv_all = 1'b0;
    chk("invf_fwd_hit", {31'd0, got}, 32'd1);
    chk("invf_fwd_word", w, 32'hBEE7_0008);
    $display("[TB] inv_all during fetch of 0x8 fwd_word=%h", w);
    req(32'h8, 0, n, w);
    chk("invf_8_iren", n, 1);
    chk("total_miss", miss_count, 11);
    chk("total_hit", hit_count, 2);

    // imemREN dropped mid-fetch: fill still lands.
    dp.imemREN = 1'b1; dp.imemaddr = 32'hC; lat = 1;
    tick();
    dp.imemREN = 1'b0;
    tick(); tick(); tick();
    $display("[TB] dropped request 0xC");
    req(32'hC, 0, n, w);
    chk("drop_then_hit", n, 0);

    dp.imemREN = 1'b1; dp.imemaddr = 32'h300; lat = 3;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #2;
    chk("rstf_iREN", {31'd0, iREN}, 32'd0);
    chk("rstf_ihit", {31'd0, dp.ihit}, 32'd0);
    chk("rstf_hit", hit_count, 0);
    chk("rstf_miss", miss_count, 0);
    tick();
    req(32'h300, 0, n, w);
    chk("rstf_300_miss", miss_count, 1);
    $display("[TB] reset during fetch of 0x300");

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
